// File: rtl/regfile_port_ctrl.sv
// Time-shares the register file's read_op1 port between operand reads and queued
// writebacks; writebacks wait in a small FIFO, stale reads are held off.
module regfile_port_ctrl #(
    parameter int DEPTH         = 4,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rd_req_i,
    input  logic [3:0]  rd_addr1_i,
    input  logic [3:0]  rd_addr2_i,
    output logic        rd_grant_o,
    output logic        rd_done_o,
    output logic [15:0] rd_op1_o,
    output logic [15:0] rd_op2_o,
    output logic [15:0] rd_r15_o,
    input  logic        wb_valid_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_addr_i,
    input  logic [15:0] wb_data_i,
    input  logic        wb_r15we_i,
    input  logic [15:0] wb_r15_data_i,
    output logic        wb_ready_o,
    output logic        rf_regWrite_o,
    output logic        rf_R15write_o,
    output logic [3:0]  rf_read_op1_o,
    output logic [3:0]  rf_read_op2_o,
    output logic [15:0] rf_wrData_o,
    output logic [15:0] rf_wrR15_Data_o,
    input  logic [15:0] rf_op1_Out_i,
    input  logic [15:0] rf_op2_Out_i,
    input  logic [15:0] rf_R15_Out_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_RD_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        r15we;
        logic [15:0] r15_data;
    } wb_ent_t;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_WRITE} slot_e;

    wb_ent_t       fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          rd_done_q;
    logic [15:0]   rd_op1_q, rd_op2_q, rd_r15_q;

    slot_e         slot;
    wb_ent_t       head, ent_in;
    logic          full, empty, hazard, push, pop;
    logic [PW-1:0] idx;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = fifo_q[rd_ptr_q];
    assign ent_in = '{we: wb_we_i, addr: wb_addr_i, data: wb_data_i,
                      r15we: wb_r15we_i, r15_data: wb_r15_data_i};

    // Only queued entries count; a same-cycle push is ordered after the read.
    always_comb begin
        hazard = 1'b0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((fifo_q[idx].we && (fifo_q[idx].addr == rd_addr1_i ||
                                        fifo_q[idx].addr == rd_addr2_i)) ||
                    fifo_q[idx].r15we)
                    hazard = 1'b1;
            end
        end
    end

    always_comb begin
        slot = SLOT_IDLE;
        if (rst_i)
            slot = SLOT_IDLE;
        else if (full)
            slot = SLOT_WRITE;
        else if (!empty && streak_q == STREAK_MAX)
            slot = SLOT_WRITE;
        else if (rd_req_i && !hazard)
            slot = SLOT_READ;
        else if (!empty)
            slot = SLOT_WRITE;
    end

    always_comb begin
        rd_grant_o      = 1'b0;
        rf_regWrite_o   = 1'b0;
        rf_R15write_o   = 1'b0;
        rf_read_op1_o   = '0;
        rf_read_op2_o   = '0;
        rf_wrData_o     = '0;
        rf_wrR15_Data_o = '0;
        case (slot)
            SLOT_WRITE: begin
                rf_read_op1_o   = head.addr;
                rf_regWrite_o   = head.we;
                rf_wrData_o     = head.data;
                rf_R15write_o   = head.r15we;
                rf_wrR15_Data_o = head.r15_data;
            end
            SLOT_READ: begin
                rf_read_op1_o = rd_addr1_i;
                rf_read_op2_o = rd_addr2_i;
                rd_grant_o    = 1'b1;
            end
            default: ;
        endcase
    end

    // Writebacks with no enable are accepted but never occupy a slot.
    assign push = wb_valid_i && !full && (wb_we_i || wb_r15we_i);
    assign pop  = (slot == SLOT_WRITE);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        streak_d = streak_q;
        if (slot == SLOT_WRITE || empty)
            streak_d = '0;
        else if (slot == SLOT_READ && streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            streak_q  <= '0;
            rd_done_q <= 1'b0;
            rd_op1_q  <= '0;
            rd_op2_q  <= '0;
            rd_r15_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q   <= count_d;
            streak_q  <= streak_d;
            rd_done_q <= (slot == SLOT_READ);
            if (slot == SLOT_READ) begin
                rd_op1_q <= rf_op1_Out_i;
                rd_op2_q <= rf_op2_Out_i;
                rd_r15_q <= rf_R15_Out_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i)
            fifo_q[wr_ptr_q] <= ent_in;
    end

    assign wb_ready_o = !full;
    assign rd_done_o  = rd_done_q;
    assign rd_op1_o   = rd_op1_q;
    assign rd_op2_o   = rd_op2_q;
    assign rd_r15_o   = rd_r15_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural register file, queue-based scheduler
// model, directed vector table, corner-case sequences and random traffic.
module tb_regfile_port_ctrl;
    localparam int DEPTH = 4;
    localparam int MAXS  = 4;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        r15we;
        logic [15:0] r15d;
    } ent_t;

    typedef struct {
        logic       pvalid, pwe, pr15;
        logic [3:0] paddr;
        logic       req;
        logic [3:0] a1, a2;
        logic       e_grant, e_wr, e_r15w;
        logic [3:0] e_op1;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rd_req, wb_valid, wb_we, wb_r15we;
    logic [3:0]  a1, a2, wb_addr;
    logic [15:0] wb_data, wb_r15d;
    logic        rd_grant, rd_done, wb_ready, rf_regWrite, rf_R15write;
    logic [15:0] rd_op1, rd_op2, rd_r15, rf_wrData, rf_wrR15_Data;
    logic [3:0]  rf_read_op1, rf_read_op2;
    logic [15:0] rf_op1_Out, rf_op2_Out, rf_R15_Out;

    regfile_port_ctrl #(.DEPTH(DEPTH), .MAX_RD_STREAK(MAXS)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(rd_req), .rd_addr1_i(a1), .rd_addr2_i(a2),
        .rd_grant_o(rd_grant), .rd_done_o(rd_done),
        .rd_op1_o(rd_op1), .rd_op2_o(rd_op2), .rd_r15_o(rd_r15),
        .wb_valid_i(wb_valid), .wb_we_i(wb_we), .wb_addr_i(wb_addr),
        .wb_data_i(wb_data), .wb_r15we_i(wb_r15we), .wb_r15_data_i(wb_r15d),
        .wb_ready_o(wb_ready),
        .rf_regWrite_o(rf_regWrite), .rf_R15write_o(rf_R15write),
        .rf_read_op1_o(rf_read_op1), .rf_read_op2_o(rf_read_op2),
        .rf_wrData_o(rf_wrData), .rf_wrR15_Data_o(rf_wrR15_Data),
        .rf_op1_Out_i(rf_op1_Out), .rf_op2_Out_i(rf_op2_Out), .rf_R15_Out_i(rf_R15_Out)
    );

    // Behavioural register file driven by the DUT's rf_* ports.
    logic [15:0] rf_mem [16];
    logic [15:0] rf_r15;
    logic        rf_init;
    assign rf_op1_Out = rf_mem[rf_read_op1];
    assign rf_op2_Out = rf_mem[rf_read_op2];
    assign rf_R15_Out = rf_r15;
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 16'hA000 + 16'(i);
            rf_r15 <= 16'hBEEF;
        end else begin
            if (rf_regWrite) rf_mem[rf_read_op1] <= rf_wrData;
            if (rf_R15write) rf_r15 <= rf_wrR15_Data;
        end
    end

    // Reference model: pending-writeback queue plus architectural register values.
    ent_t        mq[$];
    logic [15:0] arch [16];
    logic [15:0] arch_r15;
    int          m_streak, m_slot;  // slot: 0 idle, 1 read, 2 write
    bit          m_full, e_done;
    logic [15:0] e_op1, e_op2, e_r15;
    int          n_cmp = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc_eval();
        bit haz;
        @(negedge clk);
        m_full = (mq.size() == DEPTH);
        haz = 0;
        foreach (mq[i])
            if ((mq[i].we && (mq[i].addr == a1 || mq[i].addr == a2)) || mq[i].r15we) haz = 1;
        if (rst)                                     m_slot = 0;
        else if (m_full)                             m_slot = 2;
        else if (mq.size() != 0 && m_streak == MAXS) m_slot = 2;
        else if (rd_req && !haz)                     m_slot = 1;
        else if (mq.size() != 0)                     m_slot = 2;
        else                                         m_slot = 0;
        chk("rd_grant", rd_grant, m_slot == 1);
        chk("wb_ready", wb_ready, !m_full);
        chk("rf_regWrite", rf_regWrite, m_slot == 2 && mq[0].we);
        chk("rf_R15write", rf_R15write, m_slot == 2 && mq[0].r15we);
        chk("rf_read_op1", rf_read_op1, m_slot == 2 ? mq[0].addr : (m_slot == 1 ? a1 : 4'd0));
        chk("rf_read_op2", rf_read_op2, m_slot == 1 ? a2 : 4'd0);
        if (m_slot != 1) begin
            chk("rf_wrData", rf_wrData, m_slot == 2 ? mq[0].data : 16'd0);
            chk("rf_wrR15_Data", rf_wrR15_Data, m_slot == 2 ? mq[0].r15d : 16'd0);
        end
    endtask

    task automatic cyc_edge();
        ent_t h;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_streak = 0;
            e_done = 0; e_op1 = 0; e_op2 = 0; e_r15 = 0;
        end else begin
            e_done = (m_slot == 1);
            if (m_slot == 1) begin
                e_op1 = arch[a1]; e_op2 = arch[a2]; e_r15 = arch_r15;
            end
            if (m_slot == 2 || mq.size() == 0) m_streak = 0;
            else if (m_slot == 1 && m_streak < MAXS) m_streak++;
            if (m_slot == 2) begin
                h = mq.pop_front();
                if (h.we) arch[h.addr] = h.data;
                if (h.r15we) arch_r15 = h.r15d;
            end
            if (wb_valid && !m_full && (wb_we || wb_r15we)) begin
                h = '{we: wb_we, addr: wb_addr, data: wb_data, r15we: wb_r15we, r15d: wb_r15d};
                mq.push_back(h);
            end
        end
        chk("rd_done", rd_done, e_done);
        chk("rd_op1", rd_op1, e_op1);
        chk("rd_op2", rd_op2, e_op2);
        chk("rd_r15", rd_r15, e_r15);
    endtask

    task automatic cycle();
        cyc_eval();
        cyc_edge();
    endtask

    task automatic set_idle();
        rd_req = 0; a1 = 0; a2 = 0;
        wb_valid = 0; wb_we = 0; wb_addr = 0; wb_data = 0; wb_r15we = 0; wb_r15d = 0;
    endtask

    task automatic push(input logic we, input logic [3:0] ad, input logic [15:0] d,
                        input logic r15, input logic [15:0] r15d);
        wb_valid = 1; wb_we = we; wb_addr = ad; wb_data = d; wb_r15we = r15; wb_r15d = r15d;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic drain();
        set_idle();
        repeat (DEPTH + 2) cycle();
    endtask

    vec_t        vt [7];
    logic [5:0]  pat;

    initial begin
        vt[0] = '{1, 1, 0, 4'd3, 1, 4'd3, 4'd1, 0, 1, 0, 4'd3};
        vt[1] = '{1, 1, 0, 4'd3, 1, 4'd4, 4'd5, 1, 0, 0, 4'd4};
        vt[2] = '{1, 0, 1, 4'd6, 1, 4'd4, 4'd5, 0, 0, 1, 4'd6};
        vt[3] = '{1, 0, 0, 4'd6, 1, 4'd4, 4'd5, 1, 0, 0, 4'd4};
        vt[4] = '{0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0};
        vt[5] = '{1, 1, 0, 4'd9, 1, 4'd2, 4'd9, 0, 1, 0, 4'd9};
        vt[6] = '{1, 0, 0, 4'd5, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0};

        for (int i = 0; i < 16; i++) arch[i] = 16'hA000 + 16'(i);
        arch_r15 = 16'hBEEF;
        m_streak = 0; m_slot = 0; e_done = 0; e_op1 = 0; e_op2 = 0; e_r15 = 0;
        set_idle();
        rst = 1; rf_init = 1;
        cycle();
        cycle();
        rst = 0; rf_init = 0;

        // Directed vectors: one writeback offered, then a read request next cycle.
        foreach (vt[k]) begin
            do_reset();
            if (vt[k].pvalid) push(vt[k].pwe, vt[k].paddr, 16'h1234 + 16'(k), vt[k].pr15, 16'h4321);
            cycle();
            set_idle();
            rd_req = vt[k].req; a1 = vt[k].a1; a2 = vt[k].a2;
            cyc_eval();
            chk("vec_grant", rd_grant, vt[k].e_grant);
            chk("vec_regWrite", rf_regWrite, vt[k].e_wr);
            chk("vec_R15write", rf_R15write, vt[k].e_r15w);
            chk("vec_read_op1", rf_read_op1, vt[k].e_op1);
            cyc_edge();
            drain();
        end

        // Push to addr 2 while reading addr 2: read returns the old value.
        do_reset();
        rd_req = 1; a1 = 2; a2 = 2;
        push(1, 4'd2, 16'h5555, 0, 16'h0);
        cycle();
        set_idle();
        chk("same_cycle_old", rd_op1, 16'hA002);
        drain();

        // Write then read of the same register.
        do_reset();
        push(1, 4'd3, 16'h1100, 0, 16'h0);
        cycle();
        set_idle();
        rd_req = 1; a1 = 3; a2 = 1;
        cyc_eval();
        chk("wtr_grant_blocked", rd_grant, 0);
        cyc_edge();
        cyc_eval();
        chk("wtr_grant", rd_grant, 1);
        cyc_edge();
        set_idle();
        chk("wtr_done", rd_done, 1);
        chk("wtr_op1", rd_op1, 16'h1100);

        // Combined general + R15 writeback.
        do_reset();
        push(1, 4'd1, 16'h1010, 1, 16'h0001);
        cycle();
        set_idle();
        cyc_eval();
        chk("r15_regWrite", rf_regWrite, 1);
        chk("r15_R15write", rf_R15write, 1);
        cyc_edge();
        rd_req = 1; a1 = 1; a2 = 0;
        cycle();
        set_idle();
        chk("r15_op1", rd_op1, 16'h1010);
        chk("r15_r15", rd_r15, 16'h0001);

        // Starvation: four grants, one write slot, then grants again.
        do_reset();
        rd_req = 1; a1 = 1; a2 = 2;
        push(1, 4'd7, 16'h7777, 0, 16'h0);
        cycle();
        wb_valid = 0;
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            cyc_eval();
            pat = {pat[4:0], rd_grant};
            cyc_edge();
        end
        chk("starve_pattern", pat, 6'b111101);
        drain();

        // Full FIFO: ready drops after the fourth push, recovers after the forced write.
        do_reset();
        rd_req = 1; a1 = 1; a2 = 2;
        pat = '0;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) push(1, 4'(8 + c), 16'hF000 + 16'(c), 0, 16'h0);
            else wb_valid = 0;
            cyc_eval();
            pat = {pat[4:0], wb_ready};
            cyc_edge();
        end
        chk("full_ready_pattern", pat, 6'b111101);
        drain();

        // Reset mid-operation with three entries queued.
        do_reset();
        rd_req = 1; a1 = 1; a2 = 2;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) push(1, 4'(10 + c), 16'hC000 + 16'(c), 0, 16'h0);
            else wb_valid = 0;
            cycle();
        end
        set_idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            cyc_eval();
            chk("rst_no_write", rf_regWrite, 0);
            chk("rst_ready", wb_ready, 1);
            cyc_edge();
            chk("rst_op1_zero", rd_op1, 16'h0);
            chk("rst_done_zero", rd_done, 0);
        end

        // Random traffic against the model, honouring the rd_req hold rule.
        for (int c = 0; c < 600; c++) begin
            if (!(rd_req && m_slot != 1)) begin
                rd_req = ($urandom_range(0, 99) < 60);
                a1 = 4'($urandom);
                a2 = 4'($urandom);
            end
            wb_valid = ($urandom_range(0, 99) < 45);
            wb_we    = ($urandom_range(0, 99) < 80);
            wb_r15we = ($urandom_range(0, 99) < 10);
            wb_addr  = 4'($urandom);
            wb_data  = 16'($urandom);
            wb_r15d  = 16'($urandom);
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Port controller and scheduler for the 16 x 16-bit register file with its dedicated R15 write port. The register file has no separate write address: a write lands in the register selected by `read_op1`. This block therefore time-shares `read_op1` between decode-stage operand reads and queued writebacks. It buffers writebacks in a small FIFO, blocks reads that would return stale data, and bounds write starvation. It sits between decode/writeback and the register file instance.

## Interface
Parameters:
- `DEPTH`, 4 — writeback FIFO entries; power of two, 2 to 8.
- `MAX_RD_STREAK`, 4 — maximum consecutive read grants allowed while the FIFO is non-empty.

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `rd_req`  in  1  — decode requests an operand read.
- `rd_addr1`, `rd_addr2`  in  4 each  — operand register numbers.
- `rd_grant`  out  1  — read taken this cycle; combinational.
- `rd_done`  out  1  — registered operands valid; one-cycle pulse.
- `rd_op1`, `rd_op2`, `rd_r15`  out  16 each  — registered operand and R15 values.
- `wb_valid`  in  1  — writeback offered.
- `wb_we`  in  1  — general register write requested.
- `wb_addr`  in  4  — general register write destination.
- `wb_data`  in  16  — general register write data.
- `wb_r15we`  in  1  — R15 write requested.
- `wb_r15_data`  in  16  — R15 write data.
- `wb_ready`  out  1  — FIFO can accept; equals `!full`.
- `rf_regWrite`, `rf_R15write`  out  1 each  — register file write enables.
- `rf_read_op1`, `rf_read_op2`  out  4 each  — register file address ports.
- `rf_wrData`, `rf_wrR15_Data`  out  16 each  — register file write data.
- `rf_op1_Out`, `rf_op2_Out`, `rf_R15_Out`  in  16 each  — register file read data, combinational.

## Operation
- **Push.** A push happens when `wb_valid && wb_ready`.
  - The entry stored is {`we`, `addr`, `data`, `r15we`, `r15_data`}.
  - A push with `wb_we = wb_r15we = 0` is accepted and dropped, not enqueued.
  - Push while full is not permitted, even if a pop occurs in the same cycle; `wb_ready` is 0 when full.
- **Hazard.** `hazard` is 1 if any valid FIFO entry satisfies either condition:
  - `we` is set and `addr` equals `rd_addr1` or `rd_addr2`;
  - `r15we` is set (a pending R15 write blocks every read, because `rd_r15` is always captured).
  - The comparison covers FIFO contents only. A writeback pushed in the same cycle as a read grant is ordered after that read.
- **Slot decision**, evaluated each cycle, first match wins:
  1. FIFO full → WRITE.
  2. FIFO non-empty and `streak == MAX_RD_STREAK` → WRITE.
  3. `rd_req && !hazard` → READ.
  4. FIFO non-empty → WRITE.
  5. Otherwise → IDLE.
- **WRITE slot:**
  - `rf_read_op1` = head.addr, `rf_read_op2` = 0.
  - `rf_regWrite` = head.we, `rf_wrData` = head.data.
  - `rf_R15write` = head.r15we, `rf_wrR15_Data` = head.r15_data.
  - The head is popped at the clock edge.
- **READ slot:**
  - `rf_read_op1` = `rd_addr1`, `rf_read_op2` = `rd_addr2`; both write enables are 0.
  - `rd_grant` = 1.
  - At the edge, `rf_op1_Out`, `rf_op2_Out` and `rf_R15_Out` are captured into `rd_op1`, `rd_op2` and `rd_r15`.
- **IDLE slot:** all `rf_*` outputs are 0.
- **`streak` counter:**
  - Increments on a READ grant while the FIFO is non-empty.
  - Clears on a WRITE slot, or when the FIFO is empty at the edge.
  - Saturates at `MAX_RD_STREAK`.
- **`rd_op*` / `rd_r15` hold:** these hold their value until the next read grant.

## Timing
- **Reset.** Applies on the clock edge where `rst` is 1:
  - FIFO is emptied and any queued writes are discarded, with no register file write.
  - `streak` = 0, `rd_done` = 0, `rd_op1` = `rd_op2` = `rd_r15` = 0.
  - Once reset is sampled, `rf_regWrite` = `rf_R15write` = 0 and `wb_ready` = 1.
  - `rd_grant` = 0 and every `rf_*` output = 0 during the reset cycle.
- **Read latency:** `rd_grant` in cycle t → `rd_done` = 1 with data valid in cycle t+1.
- **Writeback latency:** a push in cycle t into an empty FIFO with no `rd_req` → register file write at the edge ending cycle t+1.
- **FIFO:** circular pointers with wrap-around at `DEPTH`. The count update handles a simultaneous push and pop (count unchanged).
- **Write starvation bound:** a queued head entry is written within `MAX_RD_STREAK` + 1 cycles.
- **`rd_req` hold rule:** `rd_req` must stay asserted, with stable addresses, until `rd_grant` is 1.

## Test plan
- **Reset:** assert `rst` 2 cycles mid-operation with 3 entries queued → `wb_ready` = 1, no `rf_regWrite` afterwards, all `rd_*` outputs 0.
- **Write then read:** push {we=1, addr=3, data=16'h1100}; hold `rd_req` with addr1=3, addr2=1.
  - `rd_grant` stays 0 until the write slot.
  - Next cycle the read grants; `rd_op1` = 16'h1100 one cycle later.
- **R15 write:** push {we=1, addr=1, data=16'h1010, r15we=1, r15_data=16'h0001} → both write enables are 1 in the same cycle. A following read shows `rd_op1` = 16'h1010 and `rd_r15` = 16'h0001.
- **Starvation:** `rd_req` held high with no hazard, one entry queued to addr 7 → exactly 4 consecutive grants, then one WRITE slot, then grants resume.
- **Full FIFO:** 4 back-to-back pushes with continuous non-hazard `rd_req` → `wb_ready` = 0 after the 4th push, the forced WRITE occurs, and `wb_ready` returns to 1 the next cycle.
- **Null writeback and same-cycle ordering:**
  - Push with we=0, r15we=0 → no FIFO occupancy change.
  - Push to addr 2 in the same cycle a read of addr 2 is granted → the read returns the old value.
